// File: rtl/gtxe2_chnl_rxoutclk_ctrl.sv
// -----------------------------------------------------------------------------
// gtxe2_chnl_rxoutclk_ctrl
//
// Sequenced RXOUTCLK source switcher for the GTXE2 channel simulation model.
// A requested RXOUTCLKSEL is synchronized into clk and applied in stages:
// park the output on constant 1, wait PARK_CYCLES, switch to the new source,
// then wait SETTLE_CYCLES before reporting completion. The output therefore
// never jumps directly from one clock source to another.
//
// The control path is ordinary synchronous logic. The RXOUTCLK mux selects
// between clock signals and is intended for simulation only.
//
// Handshake: there is no valid/ready pair. A new request is any change of the
// normalized, synchronized RXOUTCLKSEL_REQ. switch_busy is high from the edge a
// change is detected until completion. switch_done is a one-cycle pulse on the
// completion edge and is never high in a cycle where switch_busy is high.
//
// Ports:
//   clk               control clock (free-running)
//   rst_n             asynchronous active-low reset
//   RXOUTCLKSEL_REQ   requested source code, may be asynchronous to clk
//   RXOUTCLKPCS       PCS recovered clock        (code 001)
//   RXOUTCLKPMA       PMA recovered clock        (code 010)
//   RXPLLREFCLK_DIV1  PLL reference clock        (code 011)
//   RXPLLREFCLK_DIV2  PLL reference clock / 2    (code 100)
//   RXOUTCLK          selected clock (constant 1 for code 000)
//   sel_applied       select currently driving the mux
//   switch_busy       high while a switch sequence is in progress
//   switch_done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module gtxe2_chnl_rxoutclk_ctrl #(
  parameter int SYNC_STAGES   = 2,  // legal range 2..4
  parameter int PARK_CYCLES   = 4,  // >= 1
  parameter int SETTLE_CYCLES = 8   // >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] RXOUTCLKSEL_REQ,
  input  logic       RXOUTCLKPCS,
  input  logic       RXOUTCLKPMA,
  input  logic       RXPLLREFCLK_DIV1,
  input  logic       RXPLLREFCLK_DIV2,
  output logic       RXOUTCLK,
  output logic [2:0] sel_applied,
  output logic       switch_busy,
  output logic       switch_done
);

  localparam int CNT_MAX = ((PARK_CYCLES > SETTLE_CYCLES) ? PARK_CYCLES : SETTLE_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] PARK_LOAD   = CNT_W'(PARK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_PARK   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 3'b000;
      end
    end else begin
      sync_q[0] <= RXOUTCLKSEL_REQ;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [2:0] req_s;
  logic [2:0] req_n;

  assign req_s = sync_q[SYNC_STAGES-1];
  // Undefined codes 101..111 are treated as a request for the parked output.
  assign req_n = (req_s > 3'd4) ? 3'b000 : req_s;

  // ---------------------------------------------------------------------------
  // Switch sequencer
  // ---------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [2:0]       target_q, target_d;
  logic [2:0]       sel_q,    sel_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STABLE;
      target_q <= 3'b000;
      sel_q    <= 3'b000;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (req_n != sel_q) begin
          target_d = req_n;
          sel_d    = 3'b000;
          cnt_d    = PARK_LOAD;
          busy_d   = 1'b1;
          state_d  = ST_PARK;
        end
      end

      ST_PARK: begin
        // A changed target restarts the park; this wins over the timeout.
        if (req_n != target_q) begin
          target_d = req_n;
          sel_d    = 3'b000;
          cnt_d    = PARK_LOAD;
          state_d  = ST_PARK;
        end else if (cnt_q == '0) begin
          sel_d   = target_q;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_SETTLE: begin
        // Compared against target, not the pre-sequence select: returning to
        // the old value mid-sequence is itself a retarget.
        if (req_n != target_q) begin
          target_d = req_n;
          sel_d    = 3'b000;
          cnt_d    = PARK_LOAD;
          state_d  = ST_PARK;
        end else if (cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output clock mux (simulation-only clock selection)
  // ---------------------------------------------------------------------------
  always_comb begin
    RXOUTCLK = 1'b1;
    case (sel_q)
      3'b001:  RXOUTCLK = RXOUTCLKPCS;
      3'b010:  RXOUTCLK = RXOUTCLKPMA;
      3'b011:  RXOUTCLK = RXPLLREFCLK_DIV1;
      3'b100:  RXOUTCLK = RXPLLREFCLK_DIV2;
      default: RXOUTCLK = 1'b1;
    endcase
  end

  assign sel_applied = sel_q;
  assign switch_busy = busy_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_gtxe2_chnl_rxoutclk_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for gtxe2_chnl_rxoutclk_ctrl.
// The reference model tracks each switch sequence with absolute cycle
// deadlines (park end, completion) computed from the detection cycle, and a
// history of sampled requests to represent the synchronizer delay.
// -----------------------------------------------------------------------------
module tb_gtxe2_chnl_rxoutclk_ctrl;

  localparam int SYNC   = 2;
  localparam int PARK   = 4;
  localparam int SETTLE = 8;
  localparam int W      = 19;  // {cycle[15:0], sel[2:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset / sources
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       pcs = 1'b0, pma = 1'b0, div1 = 1'b0, div2 = 1'b0;
  logic       rxoutclk;
  logic [2:0] sel_applied;
  logic       switch_busy;
  logic       switch_done;

  initial forever #5 clk = ~clk;

  // Source clocks toggle only at odd times; outputs are sampled at even times.
  initial begin #1; forever begin pcs  = ~pcs;  #6;  end end
  initial begin #3; forever begin pma  = ~pma;  #10; end end
  initial begin #5; forever begin div1 = ~div1; #14; end end
  initial begin #7; forever begin div2 = ~div2; #4;  end end

  gtxe2_chnl_rxoutclk_ctrl #(
    .SYNC_STAGES  (SYNC),
    .PARK_CYCLES  (PARK),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .RXOUTCLKSEL_REQ (req),
    .RXOUTCLKPCS     (pcs),
    .RXOUTCLKPMA     (pma),
    .RXPLLREFCLK_DIV1(div1),
    .RXPLLREFCLK_DIV2(div2),
    .RXOUTCLK        (rxoutclk),
    .sel_applied     (sel_applied),
    .switch_busy     (switch_busy),
    .switch_done     (switch_done)
  );

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] norm(input logic [2:0] c);
    return (c > 3'd4) ? 3'd0 : c;
  endfunction

  function automatic logic src_of(input logic [2:0] c);
    case (c)
      3'd1:    return pcs;
      3'd2:    return pma;
      3'd3:    return div1;
      3'd4:    return div2;
      default: return 1'b1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  logic [2:0] hist[$];
  logic [2:0] m_sel = 3'd0;
  logic [2:0] m_target = 3'd0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  int         m_park_end = 0;
  int         m_done_at = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [2:0] seen;
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      hist.delete();
      m_sel    = 3'd0;
      m_target = 3'd0;
      m_busy   = 1'b0;
    end else begin
      hist.push_back(req);
      if (hist.size() > 8) void'(hist.pop_front());
      seen = (hist.size() > SYNC) ? norm(hist[hist.size()-1-SYNC]) : 3'd0;
      if (!m_busy) begin
        if (seen != m_sel) begin
          m_target   = seen;
          m_sel      = 3'd0;
          m_busy     = 1'b1;
          m_park_end = cyc + PARK;
          m_done_at  = m_park_end + SETTLE;
        end
      end else if (seen != m_target) begin
        m_target   = seen;
        m_sel      = 3'd0;
        m_park_end = cyc + PARK;
        m_done_at  = m_park_end + SETTLE;
      end else if (cyc == m_park_end) begin
        m_sel = m_target;
      end else if (cyc == m_done_at) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        exp_q.push_back({cyc[15:0], m_target});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      chk("sel_applied", {29'd0, sel_applied}, {29'd0, m_sel});
      chk("switch_busy", {31'd0, switch_busy}, {31'd0, m_busy});
      chk("switch_done", {31'd0, switch_done}, {31'd0, m_done});
      chk("rxoutclk",    {31'd0, rxoutclk},    {31'd0, src_of(m_sel)});
      if (switch_done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle_sel", {13'd0, cyc[15:0], sel_applied}, {13'd0, e});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] v);
    @(negedge clk);
    req = v;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    chk("reset_sel",  {29'd0, sel_applied}, 32'd0);
    chk("reset_busy", {31'd0, switch_busy}, 32'd0);
    chk("reset_done", {31'd0, switch_done}, 32'd0);
    chk("reset_clk",  {31'd0, rxoutclk},    32'd1);
    wait_cycles(3);
    rst_n = 1'b1;

    // Idle with request 000.
    wait_cycles(20);

    // 000 -> 010, then 010 -> 011.
    set_req(3'b010);
    wait_cycles(25);
    set_req(3'b011);
    wait_cycles(25);

    // Retarget 001 -> 100 while in SETTLE.
    set_req(3'b001);
    wait_cycles(10);
    set_req(3'b100);
    wait_cycles(30);

    // Undefined code maps to parked output.
    set_req(3'b011);
    wait_cycles(25);
    set_req(3'b110);
    wait_cycles(25);

    // Reset during SETTLE of 000 -> 100.
    set_req(3'b100);
    wait_cycles(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel",  {29'd0, sel_applied}, 32'd0);
    chk("async_rst_busy", {31'd0, switch_busy}, 32'd0);
    chk("async_rst_done", {31'd0, switch_done}, 32'd0);
    chk("async_rst_clk",  {31'd0, rxoutclk},    32'd1);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(25);

    // Randomized requests, including mid-sequence changes.
    for (int i = 0; i < 60; i++) begin
      set_req(3'($urandom_range(0, 7)));
      wait_cycles($urandom_range(1, 20));
    end
    wait_cycles(40);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_rxoutclk_ctrl.md
Name: gtxe2_chnl_rxoutclk_ctrl

Overview:
Receive-side counterpart of the channel TX output-clock selection: a sequenced RXOUTCLK source switcher for the GTXE2 channel simulation model.
- Takes a requested RXOUTCLKSEL, synchronizes it into clk, and applies it in stages: park, wait, switch, settle.
- RXOUTCLK therefore never jumps directly from one source to another.
- Non-synthesizable where it muxes clock signals; the control path is ordinary synchronous logic.

Parameters:
SYNC_STAGES, 2, synchronizer depth on RXOUTCLKSEL_REQ; legal range 2..4.
PARK_CYCLES, 4, clk cycles the output stays parked (select 000) before the new source is applied; must be >= 1.
SETTLE_CYCLES, 8, clk cycles after applying the new source before switch_done; must be >= 1.

Ports:
clk  input  1  control clock (free-running, e.g. DRP clock).
rst_n  input  1  asynchronous active-low reset.
RXOUTCLKSEL_REQ  input  3  requested source, may be asynchronous to clk.
RXOUTCLKPCS  input  1  PCS recovered clock (code 001).
RXOUTCLKPMA  input  1  PMA recovered clock (code 010).
RXPLLREFCLK_DIV1  input  1  PLL reference clock (code 011).
RXPLLREFCLK_DIV2  input  1  PLL reference clock /2 (code 100).
RXOUTCLK  output  1  selected clock.
sel_applied  output  3  select currently driving the mux.
switch_busy  output  1  high while a switch sequence is in progress.
switch_done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
Reset (the decided interface rule):
- One clock; reset is asynchronous and active-low.
- On rst_n low, immediately: sync flops = 000, target = 000, sel_applied = 000, state = STABLE, counter = 0, switch_busy = 0, switch_done = 0, RXOUTCLK = 1.

Input normalization and mux:
- The synchronized request req_s is normalized: codes 101, 110 and 111 map to 000.
- RXOUTCLK is purely combinational from sel_applied:
  - 001 -> RXOUTCLKPCS
  - 010 -> RXOUTCLKPMA
  - 011 -> RXPLLREFCLK_DIV1
  - 100 -> RXPLLREFCLK_DIV2
  - 000 -> constant 1

State machine:
- STABLE: if norm(req_s) != sel_applied, on the next edge:
  - target <= norm(req_s)
  - sel_applied <= 000
  - counter <= PARK_CYCLES-1
  - switch_busy <= 1
  - state <= PARK
- PARK: counter decrements each cycle. When counter == 0, on that edge:
  - sel_applied <= target
  - counter <= SETTLE_CYCLES-1
  - state <= SETTLE
- SETTLE: counter decrements. When counter == 0, on that edge:
  - switch_busy <= 0
  - switch_done <= 1 for exactly one cycle
  - state <= STABLE
- Target 000 runs the same full sequence; the output is constant 1 throughout.

Retargeting and boundaries:
- Retarget: in PARK or SETTLE, if norm(req_s) != target, then:
  - target <= norm(req_s), sel_applied <= 000, counter <= PARK_CYCLES-1, state <= PARK
  - switch_busy stays 1 and no switch_done is issued.
  - Retarget takes priority over the counter==0 transition in the same cycle.
- A request equal to the current target during PARK or SETTLE has no effect.
- A request returning to the value applied before the sequence still completes the sequence (target is the reference for comparison, not the old select).
- switch_done is asserted only on completion and never while switch_busy is high; completion and the next detection cannot share a cycle (detection happens in STABLE only).

Latency and widths:
- Latency from a stable RXOUTCLKSEL_REQ change to switch_done high = SYNC_STAGES + 1 + PARK_CYCLES + SETTLE_CYCLES edges (defaults: 15).
- The counter is wide enough for max(PARK_CYCLES, SETTLE_CYCLES)-1 and never wraps (reload only, no underflow).
- Reset mid-sequence aborts immediately to reset values; after release a nonzero request restarts a full sequence.

Test Plan:
- Reset, REQ=000 held 20 cycles -> RXOUTCLK=1, sel_applied=000, busy=0, no done pulse.
- REQ 000->010 after reset -> busy rises at edge 3; sel_applied stays 000 for 4 cycles, then 010 (RXOUTCLK follows RXOUTCLKPMA); done pulses one cycle at edge 15; busy=0 after.
- Switch 010->011 -> sel_applied goes 000 on park (RXOUTCLK=1 for 4 cycles), then 011, done at +15; check that no cycle shows 010 after park starts.
- Retarget: REQ 000->001, then 100 while in SETTLE -> sel_applied returns to 000, counter reloads, final sel_applied=100, exactly one done pulse.
- REQ=110 while sel_applied=011 -> sequence to 000, RXOUTCLK constant 1, done pulses.
- Assert rst_n low during SETTLE of a 000->100 switch -> outputs reset asynchronously (sel 000, busy 0, RXOUTCLK 1); after release with REQ=100 -> full 15-edge sequence repeats.
